// File: rtl/cpu_pkg.sv
// Shared types and widths for the write-back register file and its
// pending-write scoreboard.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_AW   = 3;
    localparam int SB_CNT_W = 2;

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    // Largest value a pending-write counter can hold before it saturates.
    localparam sb_cnt_t SB_CNT_MAX = '1;

    // What happens to one register's pending-write counter this cycle.
    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2
    } sb_op_t;

    // An issue and a retirement of the same register cancel out.
    function automatic sb_op_t sb_op(input logic inc, input logic dec);
        sb_op_t op;
        case ({inc, dec})
            2'b10:   op = SB_INC;
            2'b01:   op = SB_DEC;
            default: op = SB_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural
// register (r0 excluded) tracking issued-but-not-retired writes. Drives
// the decode stall and a sticky overflow/underflow error flag.
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t rd_a_addr_i,
    input  reg_addr_t rd_b_addr_i,
    input  logic      ret_valid_i,
    input  reg_addr_t ret_dst_i,
    input  logic      iss_valid_i,
    input  logic      iss_regwr_i,
    input  reg_addr_t iss_dst_i,
    output logic      stall_o,
    output logic      sb_err_o
);

    sb_cnt_t          cnt_q [NREGS];
    sb_cnt_t          cnt_d [NREGS];
    logic [NREGS-1:0] busy;
    logic             busy_a;
    logic             busy_b;
    logic             iss_acc;
    logic             err_q;
    logic             err_d;

    // A register is busy while writes are pending, unless its last pending
    // write retires this cycle (the read bypass supplies that data).
    always_comb begin
        busy   = '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            busy[r] = (cnt_q[r] != '0) &&
                      !((cnt_q[r] == sb_cnt_t'(1)) && ret_valid_i &&
                        (ret_dst_i == reg_addr_t'(r)));
            if (rd_a_addr_i == reg_addr_t'(r)) busy_a = busy[r];
            if (rd_b_addr_i == reg_addr_t'(r)) busy_b = busy[r];
        end
        stall_o = busy_a || busy_b;
    end

    // Counter next state: accepted issues count up, retirements count down,
    // both at once cancel; saturation at either end raises the error flag.
    always_comb begin
        iss_acc = iss_valid_i && iss_regwr_i && (iss_dst_i != '0) && !stall_o;
        err_d   = err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            case (sb_op(iss_acc && (iss_dst_i == reg_addr_t'(r)),
                        ret_valid_i && (ret_dst_i == reg_addr_t'(r))))
                SB_INC: begin
                    if (cnt_q[r] == SB_CNT_MAX) err_d = 1'b1;
                    else                        cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
                end
                SB_DEC: begin
                    if (cnt_q[r] == '0) err_d = 1'b1;
                    else                cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    // Counter and sticky error state, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end

    assign sb_err_o = err_q;

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: NREGS x 8-bit registers with r0 hardwired to
// zero, a jalr write-data mux, two combinational read ports that bypass a
// same-cycle write, and a pending-write scoreboard that stalls decode.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  data_t     wb_data_i,
    input  reg_addr_t wb_dst_i,
    input  logic      wb_regwr_i,
    input  data_t     wb_pcp1_i,
    input  logic      wb_jalr_i,
    input  reg_addr_t rd_a_addr_i,
    input  reg_addr_t rd_b_addr_i,
    output data_t     rd_a_o,
    output data_t     rd_b_o,
    input  logic      iss_valid_i,
    input  logic      iss_regwr_i,
    input  reg_addr_t iss_dst_i,
    output logic      stall_o,
    output logic      sb_err_o
);

    data_t regs_q [NREGS];
    data_t wr_data;
    logic  wr_en;

    // Select write data (jalr links PC+1) and qualify the write; r0 is never a target
    always_comb begin
        wr_data = wb_jalr_i ? wb_pcp1_i : wb_data_i;
        wr_en   = wb_regwr_i && (wb_dst_i != '0);
    end

    // Register storage; r0 is only ever cleared, so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_en && (wb_dst_i == reg_addr_t'(r))) regs_q[r] <= wr_data;
            end
        end
    end

    // One read port: r0 is zero, a same-cycle write wins, else stored value.
    function automatic data_t read_port(input reg_addr_t addr);
        data_t v;
        v = '0;
        if (addr != '0) begin
            if (wr_en && (addr == wb_dst_i)) begin
                v = wr_data;
            end else begin
                for (int r = 1; r < NREGS; r++) begin
                    if (addr == reg_addr_t'(r)) v = regs_q[r];
                end
            end
        end
        return v;
    endfunction

    // Combinational read ports with write-back bypass
    always_comb begin
        rd_a_o = read_port(rd_a_addr_i);
        rd_b_o = read_port(rd_b_addr_i);
    end

    wb_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_a_addr_i (rd_a_addr_i),
        .rd_b_addr_i (rd_b_addr_i),
        .ret_valid_i (wr_en),
        .ret_dst_i   (wb_dst_i),
        .iss_valid_i (iss_valid_i),
        .iss_regwr_i (iss_regwr_i),
        .iss_dst_i   (iss_dst_i),
        .stall_o     (stall_o),
        .sb_err_o    (sb_err_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: each driven cycle pushes its expected read data,
// stall and error values to a queue; a negedge process pops and compares.
module tb_wb_regfile;
    import cpu_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    data_t     wb_data_i;
    reg_addr_t wb_dst_i;
    logic      wb_regwr_i;
    data_t     wb_pcp1_i;
    logic      wb_jalr_i;
    reg_addr_t rd_a_addr_i;
    reg_addr_t rd_b_addr_i;
    data_t     rd_a_o;
    data_t     rd_b_o;
    logic      iss_valid_i;
    logic      iss_regwr_i;
    reg_addr_t iss_dst_i;
    logic      stall_o;
    logic      sb_err_o;

    wb_regfile #(.NREGS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_data_i   (wb_data_i),
        .wb_dst_i    (wb_dst_i),
        .wb_regwr_i  (wb_regwr_i),
        .wb_pcp1_i   (wb_pcp1_i),
        .wb_jalr_i   (wb_jalr_i),
        .rd_a_addr_i (rd_a_addr_i),
        .rd_b_addr_i (rd_b_addr_i),
        .rd_a_o      (rd_a_o),
        .rd_b_o      (rd_b_o),
        .iss_valid_i (iss_valid_i),
        .iss_regwr_i (iss_regwr_i),
        .iss_dst_i   (iss_dst_i),
        .stall_o     (stall_o),
        .sb_err_o    (sb_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        data_t a;
        data_t b;
        logic  stall;
        logic  err;
    } exp_t;

    exp_t  exp_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;
    data_t mreg [8];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every queued expectation in the middle of its cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".rd_a"},  rd_a_o, e.a);
            check({e.tag, ".rd_b"},  rd_b_o, e.b);
            check({e.tag, ".stall"}, {7'b0, stall_o},  {7'b0, e.stall});
            check({e.tag, ".err"},   {7'b0, sb_err_o}, {7'b0, e.err});
        end
    end

    task automatic idle();
        wb_regwr_i  = 1'b0;
        wb_dst_i    = '0;
        wb_data_i   = '0;
        wb_jalr_i   = 1'b0;
        wb_pcp1_i   = '0;
        iss_valid_i = 1'b0;
        iss_regwr_i = 1'b0;
        iss_dst_i   = '0;
        rd_a_addr_i = '0;
        rd_b_addr_i = '0;
    endtask

    task automatic wb(input reg_addr_t d, input data_t data, input logic jalr, input data_t pcp1);
        wb_regwr_i = 1'b1;
        wb_dst_i   = d;
        wb_data_i  = data;
        wb_jalr_i  = jalr;
        wb_pcp1_i  = pcp1;
    endtask

    task automatic iss(input reg_addr_t d);
        iss_valid_i = 1'b1;
        iss_regwr_i = 1'b1;
        iss_dst_i   = d;
    endtask

    task automatic rd(input reg_addr_t a, input reg_addr_t b);
        rd_a_addr_i = a;
        rd_b_addr_i = b;
    endtask

    // Queue the expectation for the cycle just set up, then advance one clock
    task automatic tick(input string tag, input data_t ea, input data_t eb,
                        input logic est, input logic eerr);
        exp_t e;
        e.tag = tag; e.a = ea; e.b = eb; e.stall = est; e.err = eerr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reg_addr_t d, rb;
        data_t     v, p, w, eb;
        logic      j;

        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rd(3, 5);
        tick("rst_hold", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rd(reg_addr_t'(i), reg_addr_t'(i));
            tick($sformatf("rst_r%0d", i), 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Plain write to r3, bypass then stored read
        iss(3);          tick("iss_r3",    8'h00, 8'h00, 1'b0, 1'b0);
        wb(3, 8'h5A, 1'b0, 8'h00); rd(3, 3);
                         tick("wr_r3_byp", 8'h5A, 8'h5A, 1'b0, 1'b0);
        rd(3, 0);        tick("rd_r3",     8'h5A, 8'h00, 1'b0, 1'b0);

        // jalr writes PC+1
        iss(7);          tick("iss_r7",    8'h00, 8'h00, 1'b0, 1'b0);
        wb(7, 8'hFF, 1'b1, 8'h21); rd(7, 3);
                         tick("jalr_byp",  8'h21, 8'h5A, 1'b0, 1'b0);
        rd(7, 7);        tick("jalr_rd",   8'h21, 8'h21, 1'b0, 1'b0);

        // Same-cycle write and read of r2
        iss(2);          tick("iss_r2",    8'h00, 8'h00, 1'b0, 1'b0);
        wb(2, 8'h3C, 1'b0, 8'h00); rd(2, 0);
                         tick("byp_r2",    8'h3C, 8'h00, 1'b0, 1'b0);
        rd(2, 3);        tick("rd_r2",     8'h3C, 8'h5A, 1'b0, 1'b0);

        // r0 discards writes
        wb(0, 8'hAA, 1'b0, 8'h00); rd(0, 0);
                         tick("wr_r0",     8'h00, 8'h00, 1'b0, 1'b0);
        rd(0, 2);        tick("rd_r0",     8'h00, 8'h3C, 1'b0, 1'b0);

        // r4 pending: stall on either port; a stalled issue of r6 is dropped
        iss(4);          tick("iss_r4",    8'h00, 8'h00, 1'b0, 1'b0);
        rd(4, 0); iss(6);
                         tick("stall_a4",  8'h00, 8'h00, 1'b1, 1'b0);
        rd(0, 4);        tick("stall_b4",  8'h00, 8'h00, 1'b1, 1'b0);
        wb(4, 8'h77, 1'b0, 8'h00); rd(4, 4);
                         tick("ret_r4",    8'h77, 8'h77, 1'b0, 1'b0);
        rd(4, 0);        tick("rd_r4",     8'h77, 8'h00, 1'b0, 1'b0);

        // Retire r6 at counter 0 (its stalled issue must not have counted)
        wb(6, 8'h66, 1'b0, 8'h00); rd(6, 0);
                         tick("unf_r6",    8'h66, 8'h00, 1'b0, 1'b0);
        rd(6, 0);        tick("unf_err",   8'h66, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset with counters pending; coinciding issue/write lost
        iss(3);          tick("iss_r3b",   8'h00, 8'h00, 1'b0, 1'b1);
        iss(5);          tick("iss_r5a",   8'h00, 8'h00, 1'b0, 1'b1);
        rd(3, 5);        tick("pre_rst",   8'h5A, 8'h00, 1'b1, 1'b1);
        rd(3, 5); iss(1); wb(4, 8'h99, 1'b0, 8'h00);
        #1;
        rst_n = 1'b0;
                         tick("async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        rd(1, 4);        tick("post_rst",  8'h00, 8'h00, 1'b0, 1'b0);

        // Overflow r5: three issues fill the counter, a fourth flags an error
        for (int i = 0; i < 3; i++) begin
            iss(5);      tick($sformatf("iss_r5_%0d", i), 8'h00, 8'h00, 1'b0, 1'b0);
        end
        rd(5, 0);        tick("cnt3",      8'h00, 8'h00, 1'b1, 1'b0);
        iss(5);          tick("ovf",       8'h00, 8'h00, 1'b0, 1'b0);
        rd(0, 5);        tick("ovf_err",   8'h00, 8'h00, 1'b1, 1'b1);
        wb(5, 8'h11, 1'b0, 8'h00); rd(5, 0);
                         tick("r5_dec3",   8'h11, 8'h00, 1'b1, 1'b1);
        wb(5, 8'h12, 1'b0, 8'h00); rd(5, 0);
                         tick("r5_dec2",   8'h12, 8'h00, 1'b1, 1'b1);
        rd(5, 0);        tick("r5_cnt1",   8'h12, 8'h00, 1'b1, 1'b1);
        wb(5, 8'h13, 1'b0, 8'h00); rd(5, 0);
                         tick("r5_last",   8'h13, 8'h00, 1'b0, 1'b1);
        rd(5, 5);        tick("r5_free",   8'h13, 8'h13, 1'b0, 1'b1);

        // Simultaneous issue and retire of r1 at counter 1
        iss(1);          tick("iss_r1",    8'h00, 8'h00, 1'b0, 1'b1);
        iss(1); wb(1, 8'h44, 1'b0, 8'h00); rd(0, 0);
                         tick("r1_both",   8'h00, 8'h00, 1'b0, 1'b1);
        rd(1, 0);        tick("r1_busy",   8'h44, 8'h00, 1'b1, 1'b1);
        wb(1, 8'h45, 1'b0, 8'h00); rd(1, 1);
                         tick("r1_ret",    8'h45, 8'h45, 1'b0, 1'b1);
        rd(1, 0);        tick("r1_free",   8'h45, 8'h00, 1'b0, 1'b1);

        // Random issue/retire pairs against a storage model
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mreg[5] = 8'h13;
        mreg[1] = 8'h45;
        for (int k = 0; k < 24; k++) begin
            d  = reg_addr_t'($urandom_range(1, 7));
            rb = reg_addr_t'($urandom_range(0, 7));
            v  = data_t'($urandom_range(0, 255));
            p  = data_t'($urandom_range(0, 255));
            j  = 1'($urandom_range(0, 1));
            w  = j ? p : v;
            iss(d); rd(0, rb);
            tick($sformatf("rnd_iss%0d", k), 8'h00, mreg[rb], 1'b0, 1'b1);
            eb = (rb == d) ? w : mreg[rb];
            wb(d, v, j, p); rd(d, rb);
            tick($sformatf("rnd_ret%0d", k), w, eb, 1'b0, 1'b1);
            mreg[d] = w;
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
